// File: rtl/alu_ctrl_mc_if.sv
// Decoder-to-EX handshake bundle for the registered ALU controller.
interface alu_ctrl_mc_if #(
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned CTRL_W  = 4
);
    logic               valid_i;
    logic [FUNCT_W-1:0] funct_i;
    logic [2:0]         ALUOp_i;
    logic               flush_i;
    logic               stall_o;
    logic               valid_o;
    logic [CTRL_W-1:0]  ALUCtrl_o;
    logic [2:0]         Bonus_o;
    logic               mc_start_o;
    logic               mc_busy_o;
    logic               illegal_o;

    // Decoder side: drives the op, watches stall.
    modport master (
        output valid_i, funct_i, ALUOp_i, flush_i,
        input  stall_o, valid_o, ALUCtrl_o, Bonus_o, mc_start_o, mc_busy_o, illegal_o
    );

    // Controller side.
    modport slave (
        input  valid_i, funct_i, ALUOp_i, flush_i,
        output stall_o, valid_o, ALUCtrl_o, Bonus_o, mc_start_o, mc_busy_o, illegal_o
    );
endinterface

// File: rtl/alu_ctrl_mc.sv
// Registered ALU controller: decodes ALUOp/funct with one cycle of latency and
// sequences multi-cycle MUL/DIV with a start pulse and a busy down-counter.
module alu_ctrl_mc #(
    parameter int unsigned FUNCT_W = 6,
    parameter int unsigned CTRL_W  = 4,
    parameter int unsigned MUL_LAT = 4,
    parameter int unsigned DIV_LAT = 8,
    parameter int unsigned CNT_W   = 4
) (
    input logic         clk_i,
    input logic         rst_i,
    alu_ctrl_mc_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StIssue, StMcRun} state_e;

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CTRL_W-1:0]  ctrl_q, ctrl_d;
    logic [2:0]         bonus_q, bonus_d;
    logic               start_q, start_d;
    logic               illegal_q, illegal_d;

    logic [CTRL_W-1:0]  dec_code;
    logic [2:0]         dec_bonus;
    logic               dec_illegal;
    logic               dec_mc;
    logic [CNT_W-1:0]   dec_cnt;
    logic               funct_hi_nz;
    logic               stall;
    logic               accept;

    // Any funct bit above [5:0] set makes the op undecodable.
    assign funct_hi_nz = (bus.funct_i >> 6) != '0;
    assign stall       = (state_q == StMcRun) && (cnt_q != '0);
    assign accept      = bus.valid_i && !stall && !bus.flush_i;

    // Decode the presented op into a control code and sequencing class.
    always_comb begin
        dec_code    = '0;
        dec_bonus   = 3'b000;
        dec_illegal = 1'b0;
        dec_mc      = 1'b0;
        dec_cnt     = '0;
        unique case (bus.ALUOp_i)
            3'b000: begin
                if (funct_hi_nz) begin
                    dec_illegal = 1'b1;
                end else begin
                    case (bus.funct_i[5:0])
                        6'b100000: dec_code = CTRL_W'(4'b0010);
                        6'b100010: dec_code = CTRL_W'(4'b0011);
                        6'b100100: dec_code = CTRL_W'(4'b0000);
                        6'b100101: dec_code = CTRL_W'(4'b0001);
                        6'b101010: dec_code = CTRL_W'(4'b0100);
                        6'b000000: dec_code = CTRL_W'(4'b0101);
                        6'b000110: dec_code = CTRL_W'(4'b0110);
                        6'b011000: begin
                            dec_code = CTRL_W'(4'b1001);
                            dec_mc   = 1'b1;
                            dec_cnt  = CNT_W'(MUL_LAT - 1);
                        end
                        6'b011010: begin
                            dec_code = CTRL_W'(4'b1011);
                            dec_mc   = 1'b1;
                            dec_cnt  = CNT_W'(DIV_LAT - 1);
                        end
                        6'b001000: begin
                            dec_code  = CTRL_W'(4'b1010);
                            dec_bonus = 3'b100;
                        end
                        default: dec_illegal = 1'b1;
                    endcase
                end
            end
            3'b001: dec_code = CTRL_W'(4'b0010);
            3'b010: dec_code = CTRL_W'(4'b0100);
            3'b011: dec_code = CTRL_W'(4'b0111);
            3'b100: dec_code = CTRL_W'(4'b0010);
            3'b101: dec_code = CTRL_W'(4'b0001);
            3'b110: dec_code = CTRL_W'(4'b0011);
            3'b111: dec_code = CTRL_W'(4'b1010);
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= StIdle;
            cnt_q     <= '0;
            ctrl_q    <= '0;
            bonus_q   <= 3'b000;
            start_q   <= 1'b0;
            illegal_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            ctrl_q    <= ctrl_d;
            bonus_q   <= bonus_d;
            start_q   <= start_d;
            illegal_q <= illegal_d;
        end
    end

    // Next-state: flush beats counting, counting beats accepting a new op.
    always_comb begin
        state_d   = StIdle;
        cnt_d     = '0;
        ctrl_d    = ctrl_q;
        bonus_d   = 3'b000;
        start_d   = 1'b0;
        illegal_d = 1'b0;
        if (bus.flush_i) begin
            state_d = StIdle;
        end else if (stall) begin
            state_d = StMcRun;
            cnt_d   = cnt_q - 1'b1;
        end else if (accept) begin
            if (dec_illegal) begin
                // Code register keeps the last good op.
                state_d   = StIssue;
                illegal_d = 1'b1;
            end else if (dec_mc) begin
                state_d = StMcRun;
                cnt_d   = dec_cnt;
                ctrl_d  = dec_code;
                start_d = 1'b1;
            end else begin
                state_d = StIssue;
                ctrl_d  = dec_code;
                bonus_d = dec_bonus;
            end
        end
    end

    // Outputs derived purely from registered state.
    always_comb begin
        bus.stall_o    = stall;
        bus.valid_o    = (state_q == StIssue) || ((state_q == StMcRun) && (cnt_q == '0));
        bus.ALUCtrl_o  = ctrl_q;
        bus.Bonus_o    = bonus_q;
        bus.mc_start_o = start_q;
        bus.mc_busy_o  = (state_q == StMcRun);
        bus.illegal_o  = illegal_q;
    end

endmodule
